// File: rtl/dmem_pipe_if.sv
// dmem_pipe_if: request/response bundle between a load/store unit (master)
// and the pipelined data memory dmem_pipe (slave).
//
// Handshake rules:
//   A request transfers on a rising clk edge where req_valid && req_ready.
//   A response transfers on a rising clk edge where rsp_valid && rsp_ready.
//   While valid is high and the matching ready is low, the sender holds the
//   valid flag and every payload signal stable. Ready may depend on state
//   but never on the valid signal it qualifies.
//
// Signals:
//   req_valid/req_ready   request handshake (master -> slave)
//   req_we                1 = store, 0 = load
//   req_be[NB-1:0]        byte-lane write enables (stores only)
//   req_addr[ADDR_W-1:0]  byte address
//   req_wdata[DATA_W-1:0] store data
//   rsp_valid/rsp_ready   response handshake (slave -> master)
//   rsp_rdata             load data, 0 for stores and errored requests
//   rsp_we                echo of req_we for the answered request
//   rsp_err               request was misaligned or out of range
interface dmem_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [NB-1:0]     req_be;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_we;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_we, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_we, rsp_err
  );
endinterface

// File: rtl/dmem_pipe.sv
// dmem_pipe: word-addressed data RAM with byte-lane write strobes, a
// LATENCY-stage lockstep response pipeline and valid/ready backpressure.
// Every accepted request yields exactly one response, in acceptance order.
//
// Parameters:
//   DATA_W  data width (multiple of 8), NB = DATA_W/8 byte lanes
//   DEPTH   number of words (>= 2)
//   ADDR_W  byte address width
//   LATENCY response latency in cycles, 1..4
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low
//   bus    dmem_pipe_if.slave (request and response channels)
//
// Optional build macro DMEM_PIPE_STATS_EN adds saturating 32-bit counters
//   stat_rd_cnt / stat_wr_cnt / stat_err_cnt (good loads, good stores,
//   errored requests), cleared by reset.
module dmem_pipe #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  dmem_pipe_if.slave  bus
`ifdef DMEM_PIPE_STATS_EN
  ,
  output logic [31:0] stat_rd_cnt,
  output logic [31:0] stat_wr_cnt,
  output logic [31:0] stat_err_cnt
`endif
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = (NB > 1) ? $clog2(NB) : 0;
  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] widx;
  logic [IDX_W-1:0]  idx;
  logic              misaligned;
  logic              out_of_range;
  logic              req_err;
  logic              stall;
  logic              accept;
  logic [DATA_W-1:0] load_data;

  logic              st_valid [LATENCY];
  logic              st_we    [LATENCY];
  logic              st_err   [LATENCY];
  logic [DATA_W-1:0] st_rdata [LATENCY];

  assign widx         = bus.req_addr >> OFF_W;
  assign idx          = widx[IDX_W-1:0];
  // Mask form works for NB == 1 too, where there are no offset bits.
  assign misaligned   = (bus.req_addr & ADDR_W'(NB - 1)) != '0;
  assign out_of_range = widx >= ADDR_W'(DEPTH);
  assign req_err      = misaligned || out_of_range;

  // Only the last stage can be blocked; the whole pipeline then freezes so
  // bubbles are preserved and ordering stays trivial.
  assign stall         = st_valid[LATENCY-1] && !bus.rsp_ready;
  assign bus.req_ready = !stall;
  assign accept        = bus.req_valid && !stall;

  // Combinational read; a store accepted one cycle earlier has already
  // committed, so back-to-back store/load to the same word sees new data.
  assign load_data = (bus.req_we || req_err) ? '0 : mem[idx];

  // Write port: reset dominates, errored stores never touch the array.
  always_ff @(posedge clk) begin
    if (reset && accept && bus.req_we && !req_err) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.req_be[i]) begin
          mem[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
        end
      end
    end
  end

  // Lockstep response pipeline; stage LATENCY-1 drives the response.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        st_valid[i] <= 1'b0;
        st_we[i]    <= 1'b0;
        st_err[i]   <= 1'b0;
        st_rdata[i] <= '0;
      end
    end else if (!stall) begin
      st_valid[0] <= accept;
      st_we[0]    <= accept && bus.req_we;
      st_err[0]   <= accept && req_err;
      st_rdata[0] <= accept ? load_data : '0;
      for (int i = 1; i < LATENCY; i++) begin
        st_valid[i] <= st_valid[i-1];
        st_we[i]    <= st_we[i-1];
        st_err[i]   <= st_err[i-1];
        st_rdata[i] <= st_rdata[i-1];
      end
    end
  end

  assign bus.rsp_valid = st_valid[LATENCY-1];
  assign bus.rsp_we    = st_we[LATENCY-1];
  assign bus.rsp_err   = st_err[LATENCY-1];
  assign bus.rsp_rdata = st_rdata[LATENCY-1];

`ifdef DMEM_PIPE_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_rd_cnt  <= '0;
      stat_wr_cnt  <= '0;
      stat_err_cnt <= '0;
    end else if (accept) begin
      if (req_err) begin
        if (stat_err_cnt != 32'hFFFF_FFFF) stat_err_cnt <= stat_err_cnt + 32'd1;
      end else if (bus.req_we) begin
        if (stat_wr_cnt != 32'hFFFF_FFFF) stat_wr_cnt <= stat_wr_cnt + 32'd1;
      end else begin
        if (stat_rd_cnt != 32'hFFFF_FFFF) stat_rd_cnt <= stat_rd_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/dmem_pipe.md
Name: dmem_pipe

Overview:
- Parametrised successor to the single-cycle data memory used by the MIPS top level.
- Generalises data width, depth and read latency, and adds byte-lane write strobes.
- Adds a valid/ready request/response handshake with backpressure, plus alignment and range error reporting.
- Sits between the core's load/store unit and the word-addressed RAM array; every accepted request returns exactly one response, in order.

Parameters:
DATA_W, 32, data word width in bits; must be a multiple of 8; NB = DATA_W/8 byte lanes
DEPTH, 64, number of words in the array; any value >= 2
ADDR_W, 32, width of byte address
LATENCY, 1, cycles from request acceptance to response valid; legal range 1..4

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous reset, active-low
req_valid  in  1  request present
req_ready  out  1  block can accept request this cycle
req_we  in  1  1 = store, 0 = load
req_be  in  NB  byte-lane write enables, bit i -> wdata[8i+7:8i]; ignored on loads
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  DATA_W  load data; 0 for stores and errored requests
rsp_we  out  1  echo of req_we for the request being answered
rsp_err  out  1  request was misaligned or out of range

Behaviour:
- Reset (reset == 0 at a clk edge): all pipeline valid bits cleared; rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_we=0. RAM contents are not reset. reset dominates any simultaneous request; in-flight responses are discarded.
- Acceptance: a request is accepted on a cycle with req_valid && req_ready.
- Word index: widx = req_addr >> log2(NB).
- Misalignment: req_addr[log2(NB)-1:0] != 0 -> err=1.
- Out of range: widx >= DEPTH -> err=1. An errored request performs no write and returns rdata 0.
- Store, at acceptance edge: for each i with req_be[i]=1, RAM[widx] byte i <= req_wdata byte i; other bytes unchanged. be=0 is legal and writes nothing.
- Load: the array is read combinationally in the acceptance cycle and the value captured into pipeline stage 1.
- Same-cycle ordering: a load accepted in the cycle after a store to the same word returns the updated data (the store commits at its acceptance edge).
- Pipeline: LATENCY stages, each holding {valid, we, err, rdata}.
  - Request accepted at edge T -> rsp_valid=1 from edge T+LATENCY-1 (i.e. visible LATENCY cycles after acceptance cycle) when unstalled.
- Stall: stall = rsp_valid && !rsp_ready. While stalled, all stages hold and req_ready=0.
  - Otherwise req_ready=1, including the cycle a response is consumed: full throughput of 1 request/cycle.
  - Bubbles in the pipeline do not collapse; the pipeline is a simple lockstep shift.
- Response: held stable (rsp_valid, rsp_rdata, rsp_we, rsp_err) until rsp_ready=1.
- Invariant: responses appear strictly in acceptance order.

Optional Feature:
DMEM_PIPE_STATS_EN
- Defined: adds outputs stat_rd_cnt[31:0], stat_wr_cnt[31:0], stat_err_cnt[31:0], all reset to 0.
  - Each increments by 1 on acceptance of a non-errored load, a non-errored store, or an errored request respectively.
  - Counters saturate at 32'hFFFF_FFFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset with rsp_ready=1, LATENCY=1 -> rsp_valid=0, req_ready=1. Store addr 0x10, wdata 0xDEADBEEF, be=4'hF; then load 0x10 -> response 1 cycle after load acceptance: rdata=0xDEADBEEF, err=0, we=0.
- Byte lanes: store 0x11223344 to 0x20 with be=4'hF, then store 0xAABBCCDD with be=4'b0101 -> load 0x20 returns 0x11BB33DD.
- Errors: load 0x22 (misaligned) and load 0x100 (widx 64 >= DEPTH) -> rdata=0, err=1 each. Store to 0x100 -> err=1, and a subsequent load of 0x00 is unchanged.
- Backpressure, LATENCY=3: issue 4 back-to-back loads with rsp_ready=0 -> req_ready drops to 0 after the first response appears; rsp_rdata stays stable. Raise rsp_ready -> all 4 responses delivered in order, one per cycle.
- Reset mid-operation: 2 requests in flight, assert reset=0 for 1 cycle -> rsp_valid=0 next cycle, no stale responses afterwards, RAM data written before reset is still readable.
- With DMEM_PIPE_STATS_EN defined: 3 loads, 2 stores, 1 misaligned load -> stat_rd_cnt=3, stat_wr_cnt=2, stat_err_cnt=1.
